// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the single-issue RV32I datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the
// datapath selects and is the only block that asserts the write enables.
module cpu_ctrl_fsm #(
    parameter logic [2:0] OP_R   = 3'd0,
    parameter logic [2:0] OP_I   = 3'd1,
    parameter logic [2:0] OP_BR  = 3'd2,
    parameter logic [2:0] OP_ADD = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [6:0]  opcode,
    input  logic        zero,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [1:0]  alu_src1,
    output logic [1:0]  alu_src,
    output logic        pc_src,
    output logic [2:0]  alu_op,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halted,
    output logic        illegal,
    output logic [31:0] retired
);
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    // Route class: decides which states follow EXEC and where the instruction ends.
    typedef enum logic [2:0] {
        K_WB, K_LOAD, K_STORE, K_BRANCH, K_SYS, K_ILL
    } kind_t;

    // Decoded per-instruction controls, latched once at DECODE (this is op_q).
    typedef struct packed {
        kind_t      kind;
        logic       jump;
        logic [1:0] src1;
        logic [1:0] src;
        logic       pc_src;
        logic [2:0] alu_op;
        logic       wb_sel;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [6:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OPC_R:      c.alu_op = OP_R;
            OPC_I:      begin c.src = 2'd1; c.alu_op = OP_I; end
            OPC_LOAD:   begin c.kind = K_LOAD;  c.src = 2'd1; c.alu_op = OP_ADD; c.wb_sel = 1'b1; end
            OPC_STORE:  begin c.kind = K_STORE; c.src = 2'd1; c.alu_op = OP_ADD; end
            OPC_BRANCH: begin c.kind = K_BRANCH; c.alu_op = OP_BR; end
            OPC_JAL:    begin c.jump = 1'b1; c.src1 = 2'd2; c.src = 2'd2; c.alu_op = OP_ADD; end
            OPC_JALR:   begin c.jump = 1'b1; c.src1 = 2'd2; c.src = 2'd2; c.alu_op = OP_ADD; c.pc_src = 1'b1; end
            OPC_LUI:    begin c.src1 = 2'd1; c.src = 2'd1; c.alu_op = OP_ADD; end
            OPC_AUIPC:  begin c.src1 = 2'd2; c.src = 2'd1; c.alu_op = OP_ADD; end
            OPC_SYSTEM: c.kind = K_SYS;
            default:    c.kind = K_ILL;
        endcase
        return c;
    endfunction

    state_t state;
    ctrl_t  dec;
    ctrl_t  ctl_q;
    logic   pc_we_q;
    logic   pc_sel_q;
    logic   store_done;
    logic   finish;

    // Decode the incoming opcode; only consumed in DECODE.
    always_comb begin
        dec = decode(opcode);
    end

    // Final cycle of the current instruction: branch in EXEC, store on its ack, or WB.
    always_comb begin
        store_done = (state == S_MEM) && dmem_ack && (ctl_q.kind == K_STORE);
        finish     = 1'b0;
        case (state)
            S_EXEC:  finish = (ctl_q.kind == K_BRANCH);
            S_MEM:   finish = store_done;
            S_WB:    finish = 1'b1;
            default: finish = 1'b0;
        endcase
    end

    // Ack-qualified strobes; everything else comes straight from registers.
    assign ir_we    = (state == S_FETCH) && imem_ack;
    assign pc_we    = pc_we_q | store_done;
    assign pc_sel   = pc_sel_q | ((state == S_EXEC) && (ctl_q.kind == K_BRANCH) && zero);
    assign alu_src1 = ctl_q.src1;
    assign alu_src  = ctl_q.src;
    assign pc_src   = ctl_q.pc_src;
    assign alu_op   = ctl_q.alu_op;
    assign wb_sel   = ctl_q.wb_sel;

    // Sequencer: state plus registered outputs set on entry to each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ctl_q    <= '0;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            pc_we_q  <= 1'b0;
            pc_sel_q <= 1'b0;
            reg_we   <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            retired  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        state    <= S_DECODE;
                        imem_req <= 1'b0;
                    end
                end
                S_DECODE: begin
                    case (dec.kind)
                        K_ILL: begin
                            state   <= S_HALT;
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                        end
                        K_SYS: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        default: begin
                            state   <= S_EXEC;
                            ctl_q   <= dec;
                            // a branch ends in EXEC, so its PC strobe is armed now
                            pc_we_q <= (dec.kind == K_BRANCH);
                        end
                    endcase
                end
                S_EXEC: begin
                    case (ctl_q.kind)
                        K_LOAD, K_STORE: begin
                            state    <= S_MEM;
                            dmem_req <= 1'b1;
                            dmem_we  <= (ctl_q.kind == K_STORE);
                        end
                        K_WB: begin
                            state    <= S_WB;
                            pc_we_q  <= 1'b1;
                            reg_we   <= 1'b1;
                            pc_sel_q <= ctl_q.jump;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (ctl_q.kind == K_LOAD) begin
                            state   <= S_WB;
                            pc_we_q <= 1'b1;
                            reg_we  <= 1'b1;
                        end
                    end
                end
                S_WB:    ;
                S_HALT:  ;
                default: state <= S_IDLE;
            endcase

            // Retirement overrides the per-state updates above.
            if (finish) begin
                state    <= S_FETCH;
                imem_req <= 1'b1;
                ctl_q    <= '0;
                pc_we_q  <= 1'b0;
                pc_sel_q <= 1'b0;
                reg_we   <= 1'b0;
                retired  <= retired + 32'd1;
            end
        end
    end
endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle control sequencer for the single-issue RV32I datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. For each step it drives the ALU operand selects, ALU operation class and next-PC source, and it handshakes with instruction and data memory. It sits beside the ALU, register file and PC register, and is the only block that asserts their write enables.

## Interface
Parameters:
- OP_R, default 3'd0: alu_op code for R-type.
- OP_I, default 3'd1: alu_op code for I-type ALU.
- OP_BR, default 3'd2: alu_op code for branch compare.
- OP_ADD, default 3'd3: alu_op code for forced add (address, link, LUI/AUIPC).

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- run  in  1  Leaves IDLE when high.
- opcode  in  7  instr[6:0], valid from DECODE onward.
- zero  in  1  ALU branch-condition result (1 = taken).
- imem_ack  in  1  Instruction word valid this cycle.
- dmem_ack  in  1  Data access complete this cycle.
- imem_req  out  1  Instruction fetch request.
- dmem_req  out  1  Data access request.
- dmem_we  out  1  Data access is a store.
- ir_we  out  1  Instruction register load strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 = PC+4, 1 = ALU PCout.
- alu_src1  out  2  0 = rs1, 1 = zero, 2 = PC.
- alu_src  out  2  0 = rs2, 1 = imm, 2 = constant 4.
- pc_src  out  1  PCout base: 0 = PC, 1 = rs1.
- alu_op  out  3  Operation class.
- reg_we  out  1  Register file write strobe.
- wb_sel  out  1  0 = ALU result, 1 = load data.
- halted  out  1  Stopped on ECALL/illegal.
- illegal  out  1  Halt cause was an illegal opcode.
- retired  out  32  Retired instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- **IDLE:** moves to FETCH when run=1.
- **FETCH:** imem_req=1 until imem_ack. On the ack cycle, ir_we=1 and the next state is DECODE.
- **DECODE:** one cycle; latches opcode into op_q.
  - Opcodes other than those listed under EXEC → HALT with illegal=1.
  - 1110011 (SYSTEM) → HALT with illegal=0.
- **EXEC and later:** alu_src1, alu_src, pc_src, alu_op and wb_sel are decoded from op_q. They are valid and stable from EXEC until the instruction finishes.
- Controls per opcode (src1 = alu_src1, src = alu_src):
  - R 0110011: src1=0, src=0, OP_R. Route EXEC→WB.
  - I 0010011: src1=0, src=1, OP_I. Route EXEC→WB.
  - LOAD 0000011: src1=0, src=1, OP_ADD, wb_sel=1. Route EXEC→MEM→WB.
  - STORE 0100011: src1=0, src=1, OP_ADD, dmem_we=1. Route EXEC→MEM, final cycle on dmem_ack.
  - BRANCH 1100011: src1=0, src=0, OP_BR, pc_src=0. Final cycle is EXEC, with pc_sel=zero.
  - JAL 1101111: src1=2, src=2, OP_ADD, pc_src=0, pc_sel=1. Route EXEC→WB.
  - JALR 1100111: as JAL but pc_src=1.
  - LUI 0110111: src1=1, src=1, OP_ADD. Route EXEC→WB.
  - AUIPC 0010111: src1=2, src=1, OP_ADD. Route EXEC→WB.
- **MEM:** dmem_req=1 held until dmem_ack.
- **Final cycle of each instruction:**
  - Asserts pc_we=1 for exactly one cycle.
  - pc_sel=0 except for JAL/JALR, and for a branch with zero=1.
  - For WB-ending instructions, reg_we=1 in the same cycle.
  - Increments retired (wraps 0xFFFFFFFF→0) and returns to FETCH.
- **HALT:** all strobes 0 and halted=1. Only rst exits HALT.
- dmem_we is 0 whenever dmem_req=0.

## Timing
- **Reset:** rst=1 forces IDLE immediately, without waiting for a clock edge.
  - All outputs go to 0 and retired=0, including alu_src1, alu_src, alu_op and pc_sel.
  - In-flight requests drop in the same cycle; a late ack is ignored.
- **Strobe timing:** all strobes are Moore outputs of state plus op_q. The only exceptions are the ack-qualified ir_we, and pc_we/reg_we at the MEM→final transition.
- **Zero-wait latency (ack in the request cycle):**
  - R/I/JAL/JALR/LUI/AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- **Wait states:** each wait cycle on imem_ack/dmem_ack adds exactly one cycle. The requests and all controls hold stable while waiting.
- **Spurious acks:** imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- **run:** sampled only in IDLE; deasserting run mid-instruction has no effect.

## Test plan
- **Reset mid-MEM:** hold dmem_ack=0 on a LOAD, then pulse rst. Required: dmem_req drops in the same cycle, state is IDLE, retired=0, and a following dmem_ack=1 causes no reg_we.
- **R-type, zero-wait:** imem_ack tied to 1, opcode=0110011. Required: pc_we and reg_we high in cycle 4 only, alu_op=OP_R, retired=1.
- **LOAD with 2 wait states:** dmem_ack arrives on the 3rd MEM cycle. Required:
  - dmem_req high for 3 cycles, dmem_we=0.
  - reg_we with wb_sel=1 at cycle 7.
- **BRANCH zero=1, then zero=0:** Required: pc_we at EXEC with pc_sel=1, then with pc_sel=0; reg_we never asserted.
- **JALR:** Required: in WB, alu_src1=2, alu_src=2, pc_src=1, pc_sel=1, and reg_we=pc_we=1.
- **Halt causes:**
  - opcode=1111111: HALT with halted=1, illegal=1, and no pc_we afterwards, even with run=1 and acks toggling.
  - opcode=1110011: HALT with illegal=0.
